// File: rtl/regfile_mp_pkg.sv
// regfile_pkg: shared types and default sizes for the multi-port register file.
//   rf_state_e : clear-sequencer states (RF_CLEAR while zeroing, RF_READY once usable)
//   RF_*       : default entry width, address width and read-port count
package regfile_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_NREAD  = 2;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: bus between the register file and its users.
//   master: drives Flush, both write ports and the packed read addresses
//   slave : returns the packed read data and Ready
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned NREAD  = RF_NREAD
);

  logic                      Flush;
  logic                      WrEn0;
  logic [ADDR_W-1:0]         WrAddr0;
  logic [DATA_W-1:0]         WrData0;
  logic                      WrEn1;
  logic [ADDR_W-1:0]         WrAddr1;
  logic [DATA_W-1:0]         WrData1;
  logic [NREAD*ADDR_W-1:0]   RdAddr;
  logic [NREAD*DATA_W-1:0]   RdData;
  logic                      Ready;

  modport master (
    output Flush, WrEn0, WrAddr0, WrData0, WrEn1, WrAddr1, WrData1, RdAddr,
    input  RdData, Ready
  );

  modport slave (
    input  Flush, WrEn0, WrAddr0, WrData0, WrEn1, WrAddr1, WrData1, RdAddr,
    output RdData, Ready
  );

endinterface

// File: rtl/regfile_mp_clear_seq.sv
// regfile_clear_seq: walks every entry writing zero after reset or an accepted flush.
//   clk, rst_n : clock, synchronous active-low reset
//   flush      : clear request, honoured only in RF_READY
//   clr_en_c   : write zero to clr_addr on this edge
//   clr_addr   : entry being cleared
//   ready      : clear finished, file usable
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  output logic              clr_en_c,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  rf_state_e         state, state_nxt;
  logic [ADDR_W-1:0] clr_ptr, ptr_nxt;

  // State, pointer and registered Ready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= RF_CLEAR;
      clr_ptr <= '0;
      ready   <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= ptr_nxt;
      ready   <= (state_nxt == RF_READY);
    end
  end

  // Next state; the clear write is held off during reset so memory is untouched
  always_comb begin
    state_nxt = state;
    ptr_nxt   = clr_ptr;
    clr_en_c  = 1'b0;
    case (state)
      RF_CLEAR: begin
        clr_en_c = rst_n;
        ptr_nxt  = clr_ptr + ADDR_W'(1);
        if (clr_ptr == LAST_ADDR) state_nxt = RF_READY;
      end
      RF_READY: begin
        if (flush) begin
          state_nxt = RF_CLEAR;
          ptr_nxt   = '0;
        end
      end
      default: state_nxt = RF_CLEAR;
    endcase
  end

  assign clr_addr = clr_ptr;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file, NREAD async read ports, two write ports
// (port 1 wins on collision) and a hardware clear after reset/flush.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : regfile_mp_if slave (Flush, WrEn/WrAddr/WrData 0/1, RdAddr, RdData, Ready)
// Optional macro REGFILE_BYPASS_EN: reads matching a committing write return the
// incoming write data in the same cycle.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned NREAD    = RF_NREAD,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mp_if.slave  bus
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_en_c;
  logic [ADDR_W-1:0] clr_addr;
  logic              ready;
  logic              wr_ok_c, we0_c, we1_c;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  regfile_clear_seq #(.ADDR_W(ADDR_W)) u_clr (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (bus.Flush),
    .clr_en_c (clr_en_c),
    .clr_addr (clr_addr),
    .ready    (ready)
  );

  // A user write commits only in READY, outside reset, and not alongside a flush
  assign wr_ok_c = ready & rst_n & ~bus.Flush;
  assign we0_c   = wr_ok_c & bus.WrEn0 & ~is_zero(bus.WrAddr0);
  assign we1_c   = wr_ok_c & bus.WrEn1 & ~is_zero(bus.WrAddr1);

  // Storage; port 1 is assigned last so it wins an address collision
  always_ff @(posedge clk) begin
    if (clr_en_c) begin
      mem[clr_addr] <= '0;
    end else begin
      if (we0_c) mem[bus.WrAddr0] <= bus.WrData0;
      if (we1_c) mem[bus.WrAddr1] <= bus.WrData1;
    end
  end

  // Independent combinational read ports
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd_c;

    assign ra = bus.RdAddr[k*ADDR_W +: ADDR_W];

    always_comb begin
      rd_c = '0;
      if (ready && !is_zero(ra)) begin
        rd_c = mem[ra];
`ifdef REGFILE_BYPASS_EN
        if (we1_c && (bus.WrAddr1 == ra))      rd_c = bus.WrData1;
        else if (we0_c && (bus.WrAddr0 == ra)) rd_c = bus.WrData0;
`endif
      end
    end

    assign bus.RdData[k*DATA_W +: DATA_W] = rd_c;
  end

  assign bus.Ready = ready;

endmodule
